// File: rtl/rename_pkg.sv
// Rename-path constants and tag type shared by the free list, ROB and map table.
package rename_pkg;

    localparam int PR_W      = 7;
    localparam int FL_DEPTH  = 96;
    localparam int ARCH_REGS = 32;

    typedef logic [PR_W-1:0] pr_tag_t;
    typedef logic [6:0]      fl_ptr_t;

    localparam pr_tag_t NULL_PR = 7'h7f;

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical-register tags: hands out up to two tags per
// cycle to dispatch and reclaims up to two retired tags per cycle.
module free_list
    import rename_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      id_dispatch_num,
    input  logic [1:0]      fl_retire_num,
    input  logic [PR_W-1:0] fl_retire_tag_a,
    input  logic [PR_W-1:0] fl_retire_tag_b,
    output logic [PR_W-1:0] fl_pr0,
    output logic [PR_W-1:0] fl_pr1,
    output logic [1:0]      fl_avail_num,
    output logic [6:0]      fl_count,
    output logic            fl_err
);

    pr_tag_t    entry [FL_DEPTH];
    fl_ptr_t    head;
    fl_ptr_t    tail;
    logic [6:0] count;

    function automatic fl_ptr_t ptr_add(input fl_ptr_t p, input logic [1:0] k);
        logic [7:0] s;
        s = {1'b0, p} + {6'b0, k};
        if (s >= 8'(FL_DEPTH)) s = s - 8'(FL_DEPTH);
        return s[6:0];
    endfunction

    logic [1:0] req;
    logic [1:0] avail;
    logic [1:0] grant;
    logic       over_req;
    logic       valid_a;
    logic       valid_b;
    pr_tag_t    first_tag;
    logic [1:0] freed;
    logic [7:0] room;
    logic [1:0] write_num;
    logic       overflow;
    logic [6:0] count_next;

    always_comb begin
        req      = (id_dispatch_num == 2'd3) ? 2'd2 : id_dispatch_num;
        avail    = (count >= 7'd2) ? 2'd2 : count[1:0];
        over_req = (req > avail);
        grant    = over_req ? avail : req;

        // NULL_PR slots are dropped; a surviving tag_b packs down to tail.
        valid_a   = (fl_retire_num != 2'd0) && (fl_retire_tag_a != NULL_PR);
        valid_b   = fl_retire_num[1] && (fl_retire_tag_b != NULL_PR);
        first_tag = valid_a ? fl_retire_tag_a : fl_retire_tag_b;
        freed     = {1'b0, valid_a} + {1'b0, valid_b};

        room       = 8'(FL_DEPTH) - {1'b0, count} + {6'b0, grant};
        overflow   = ({6'b0, freed} > room);
        write_num  = overflow ? room[1:0] : freed;
        count_next = count - {5'b0, grant} + {5'b0, write_num};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++)
                entry[i] <= (i < FL_DEPTH - 1) ? PR_W'(ARCH_REGS + i) : NULL_PR;
            head   <= '0;
            tail   <= fl_ptr_t'(FL_DEPTH - 1);
            count  <= 7'(FL_DEPTH - 1);
            fl_err <= 1'b0;
        end else begin
            if (write_num != 2'd0)
                entry[tail] <= first_tag;
            if (write_num == 2'd2)
                entry[ptr_add(tail, 2'd1)] <= fl_retire_tag_b;
            head  <= ptr_add(head, grant);
            tail  <= ptr_add(tail, write_num);
            count <= count_next;
            if (over_req || overflow)
                fl_err <= 1'b1;
        end
    end

    // Reads see registered state only, so a tag freed this cycle is not bypassed.
    always_comb begin
        fl_pr0       = (count != 7'd0) ? entry[head] : NULL_PR;
        fl_pr1       = (count >= 7'd2) ? entry[ptr_add(head, 2'd1)] : NULL_PR;
        fl_avail_num = avail;
        fl_count     = count;
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: a queue model of free tags serves as the
// scoreboard for the tags dispatch should receive.
module tb_free_list;
    import rename_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      id_dispatch_num;
    logic [1:0]      fl_retire_num;
    logic [PR_W-1:0] fl_retire_tag_a;
    logic [PR_W-1:0] fl_retire_tag_b;
    logic [PR_W-1:0] fl_pr0;
    logic [PR_W-1:0] fl_pr1;
    logic [1:0]      fl_avail_num;
    logic [6:0]      fl_count;
    logic            fl_err;

    free_list dut (
        .clock           (clock),
        .reset           (reset),
        .id_dispatch_num (id_dispatch_num),
        .fl_retire_num   (fl_retire_num),
        .fl_retire_tag_a (fl_retire_tag_a),
        .fl_retire_tag_b (fl_retire_tag_b),
        .fl_pr0          (fl_pr0),
        .fl_pr1          (fl_pr1),
        .fl_avail_num    (fl_avail_num),
        .fl_count        (fl_count),
        .fl_err          (fl_err)
    );

    always #5 clock = ~clock;

    int   n_vec = 0;
    int   n_bad = 0;
    int   q[$];
    int   inflight[$];
    logic m_err;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        inflight.delete();
        for (int i = 0; i < FL_DEPTH - 1; i++) q.push_back(ARCH_REGS + i);
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        int e0, e1, ea;
        e0 = (q.size() > 0) ? q[0] : int'(NULL_PR);
        e1 = (q.size() > 1) ? q[1] : int'(NULL_PR);
        ea = (q.size() >= 2) ? 2 : q.size();
        check_val({tag, "_pr0"},   32'(fl_pr0),       32'(e0));
        check_val({tag, "_pr1"},   32'(fl_pr1),       32'(e1));
        check_val({tag, "_avail"}, 32'(fl_avail_num), 32'(ea));
        check_val({tag, "_count"}, 32'(fl_count),     32'(q.size()));
        check_val({tag, "_err"},   32'(fl_err),       32'(m_err));
    endtask

    task automatic set_idle();
        id_dispatch_num = 2'd0;
        fl_retire_num   = 2'd0;
        fl_retire_tag_a = NULL_PR;
        fl_retire_tag_b = NULL_PR;
    endtask

    // Drive one cycle, check the pre-edge outputs, then advance the model.
    task automatic step(input int d, input int rn, input int ta, input int tb);
        int req, av, g;
        id_dispatch_num = 2'(d);
        fl_retire_num   = 2'(rn);
        fl_retire_tag_a = PR_W'(ta);
        fl_retire_tag_b = PR_W'(tb);
        #1;
        check_outputs("cyc");
        req = (d == 3) ? 2 : d;
        av  = (q.size() >= 2) ? 2 : q.size();
        g   = (req > av) ? av : req;
        if (req > av) m_err = 1'b1;
        for (int i = 0; i < g; i++) inflight.push_back(q.pop_front());
        if (rn >= 1 && ta != int'(NULL_PR)) begin
            if (q.size() < FL_DEPTH) q.push_back(ta); else m_err = 1'b1;
        end
        if (rn >= 2 && tb != int'(NULL_PR)) begin
            if (q.size() < FL_DEPTH) q.push_back(tb); else m_err = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        set_idle();
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d, rn, ta, tb;
        set_idle();
        reset = 1'b1;
        model_reset();
        #12;
        check_val("rst_pr0",   32'(fl_pr0),       32'd32);
        check_val("rst_pr1",   32'(fl_pr1),       32'd33);
        check_val("rst_avail", 32'(fl_avail_num), 32'd2);
        check_val("rst_count", 32'(fl_count),     32'd95);
        check_val("rst_err",   32'(fl_err),       32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        repeat (5) step(0, 0, 0, 0);
        step(2, 0, 0, 0);
        check_val("alloc2_pr0",   32'(fl_pr0),   32'd34);
        check_val("alloc2_count", 32'(fl_count), 32'd93);
        step(1, 0, 0, 0);
        check_val("alloc1_pr0",   32'(fl_pr0),   32'd35);
        check_val("alloc1_count", 32'(fl_count), 32'd92);
        step(2, 2, 5, 9);
        check_val("swap_count", 32'(fl_count), 32'd92);

        while (q.size() > 0) step((q.size() >= 2) ? 2 : 1, 0, 0, 0);

        step(0, 2, int'(NULL_PR), 12);
        check_val("null_a_count", 32'(fl_count), 32'd1);
        check_val("null_a_pr0",   32'(fl_pr0),   32'd12);
        step(1, 0, 0, 0);
        step(0, 1, 40, 0);
        check_val("nobypass_pr0", 32'(fl_pr0), 32'd40);
        step(2, 0, 0, 0);
        check_val("overreq_err",   32'(fl_err),   32'd1);
        check_val("overreq_count", 32'(fl_count), 32'd0);
        step(0, 0, 0, 0);

        do_reset("rst2");
        step(0, 2, 100, 101);
        check_val("ovf_count", 32'(fl_count), 32'd96);
        check_val("ovf_err",   32'(fl_err),   32'd1);
        while (q.size() > 0) step(2, 0, 0, 0);

        do_reset("rst3");
        for (int c = 0; c < 300; c++) begin
            if (c == 150) begin
                #2;
                set_idle();
                reset = 1'b1;
                #1;
                model_reset();
                check_outputs("mid_rst");
                @(negedge clock);
                reset = 1'b0;
                @(posedge clock);
                #1;
            end
            d = (q.size() >= 2) ? ((c % 5 == 0) ? 3 : 2) : q.size();
            rn = 0;
            ta = int'(NULL_PR);
            tb = int'(NULL_PR);
            if (inflight.size() > 6) begin
                rn = ($urandom_range(0, 3) == 0) ? 1 : 2;
                ta = inflight.pop_front();
                if (rn == 2) tb = inflight.pop_front();
            end
            step(d, rn, ta, tb);
        end
        check_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical-register tags for the R10K-style rename path.
- Supplies up to two new destination tags per cycle to dispatch (consumed by ROB/map table as fl_pr0/fl_pr1).
- Reclaims up to two tags per cycle from ROB retirement (fl_retire_tag_a/b, fl_retire_num).
- Sits between ROB retire and the id/dispatch stage.

Parameters:
- PR_W, 7, physical tag width.
- FL_DEPTH, 96, entry storage (128 tags minus 32 architectural mappings, rounded up).
- ARCH_REGS, 32, PRs 0..31 are mapped at reset and never start in the free list.
- NULL_PR, 7'h7f, reserved "no tag" value. Never allocated and never stored.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_dispatch_num  in  2  tags consumed this cycle (0,1,2; 3 is treated as 2).
- fl_retire_num  in  2  tags freed this cycle (0,1,2; 3 is treated as 2).
- fl_retire_tag_a  in  PR_W  first freed tag, valid when fl_retire_num>=1.
- fl_retire_tag_b  in  PR_W  second freed tag, valid when fl_retire_num==2.
- fl_pr0  out  PR_W  tag at head. NULL_PR if count==0.
- fl_pr1  out  PR_W  tag at head+1. NULL_PR if count<2.
- fl_avail_num  out  2  min(count,2). Dispatch must not request more than this.
- fl_count  out  7  current occupancy, 0..FL_DEPTH.
- fl_err  out  1  sticky error flag.

Behaviour:
- State:
  - entry[FL_DEPTH] of PR_W.
  - head, tail pointers: 0..FL_DEPTH-1, wrap explicitly at FL_DEPTH (not power-of-two).
  - count register.
- Async reset, effective immediately, including mid-operation:
  - entry[i]=ARCH_REGS+i for i<95; entry[95]=NULL_PR.
  - head=0, tail=95, count=95, fl_err=0.
  - Resulting outputs: fl_pr0=32, fl_pr1=33, fl_avail_num=2, fl_count=95.
- fl_pr0, fl_pr1, fl_avail_num, fl_count are combinational from registered state only. There is no input-to-output path.
- Allocate:
  - grant = min(id_dispatch_num (3->2), avail).
  - head advances by grant at the clock edge, modulo FL_DEPTH.
  - Over-request (id_dispatch_num > fl_avail_num): grant is clamped and fl_err is set.
- Free:
  - Each freed tag is written at tail, tail+1 (modulo), then tail advances by fl_retire_num.
  - A tag equal to NULL_PR is dropped: no write and no tail advance for that slot. The remaining valid tag packs to tail.
  - A freed tag is visible on fl_pr0/fl_pr1 no earlier than the cycle after its write. There is no same-cycle bypass, even when count==0.
- Simultaneous allocate and free:
  - count_next = count - grant + freed.
  - Reads use old head/count; writes use old tail. No conflict, because freed slots are never at head while count>0.
- Overflow: if count - grant + freed > FL_DEPTH, excess writes are dropped, count saturates at FL_DEPTH, and fl_err is set.
- fl_err clears only on reset.
- No misprediction recovery in this revision. Checkpoint restore is a future port.

Decomposition:
- Shared package `rename_pkg`: PR_W, NULL_PR, ARCH_REGS, FL_DEPTH, and a pr_tag_t typedef. The ROB and map table share these.
- Single module. A local modular-increment function (ptr_add(p,k) wrapping at FL_DEPTH) covers the pointer math. No sub-module is warranted.

Test Plan:
- Reset release, no traffic -> fl_pr0=32, fl_pr1=33, fl_avail_num=2, fl_count=95, fl_err=0, stable over 5 cycles.
- id_dispatch_num=2 for one cycle -> next cycle fl_pr0=34, fl_pr1=35, fl_count=93. id_dispatch_num=1 -> fl_pr0=35, fl_count=92.
- fl_retire_num=2, tags 5 and 9, with id_dispatch_num=2 in the same cycle -> fl_count unchanged. After allocating all remaining tags (up to 126), fl_pr0=5 then fl_pr1=9 appear in order.
- fl_retire_num=2 with tag_a=NULL_PR, tag_b=12 -> fl_count +1, only 12 enqueued. With count==0, retire one tag 40 -> fl_pr0=NULL_PR that cycle, 40 the next cycle.
- Drain to count=1 then id_dispatch_num=2 -> grant 1, fl_count=0, fl_pr0=NULL_PR, fl_err=1.
- Alternate allocate/free for 300 cycles so head/tail wrap past 95 at least three times -> the tag sequence out equals the sequence in (scoreboard), and fl_count stays consistent. Assert reset mid-run -> outputs return to reset values within the same cycle.
